// File: rtl/vec_ldst_unit_if.sv
// Data-memory port of the vector load/store sequencer: one element-wide
// request channel with a ready handshake and an in-order read return.
interface vec_ldst_unit_if #(
  parameter int ADDR_W = 16,
  parameter int ELEM_W = 16
);
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_re;
  logic              mem_we;
  logic [ELEM_W-1:0] mem_wdata;
  logic              mem_rdy;
  logic              mem_rvalid;
  logic [ELEM_W-1:0] mem_rdata;

  modport master (
    output mem_addr, mem_re, mem_we, mem_wdata,
    input  mem_rdy, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_addr, mem_re, mem_we, mem_wdata,
    output mem_rdy, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/vec_ldst_unit.sv
// Vector load/store sequencer: moves one NELEM-element vector between the
// vector datapath and an element-wide data memory, one element per beat.
module vec_ldst_unit #(
  parameter int ELEM_W = 16,
  parameter int NELEM  = 16,
  parameter int ADDR_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [3:0]               opcode,
  input  logic [ADDR_W-1:0]        addr,
  input  logic [ELEM_W*NELEM-1:0]  st_data,
  output logic                     busy,
  output logic                     done,
  output logic [ELEM_W*NELEM-1:0]  ld_data,
  vec_ldst_unit_if.master          mem
);

  localparam int IDX_W = $clog2(NELEM);
  localparam int CNT_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NELEM - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NELEM);
  localparam logic [3:0] OP_VLD = 4'b0100;
  localparam logic [3:0] OP_VST = 4'b0101;

  typedef enum logic [1:0] {IDLE, LOAD, STORE} state_t;

  state_t                    state_q, state_d;
  logic [CNT_W-1:0]          req_cnt;   // requests accepted by memory
  logic [CNT_W-1:0]          rsp_cnt;   // load beats captured
  logic [ADDR_W-1:0]         base_addr;
  logic [ELEM_W-1:0]         st_buf [NELEM];
  logic [ELEM_W-1:0]         shadow [NELEM];
  logic [ELEM_W*NELEM-1:0]   ld_next;
  logic                      accept_ld, accept_st;
  logic                      req_fire, capture, finish;

  assign accept_ld = (state_q == IDLE) && start && (opcode == OP_VLD);
  assign accept_st = (state_q == IDLE) && start && (opcode == OP_VST);
  assign busy      = (state_q != IDLE);

  // NOTE: every output of this block is given a default before the case so
  // that no path leaves a signal unassigned, which would infer a latch.
  always_comb begin
    state_d        = state_q;
    req_fire       = 1'b0;
    capture        = 1'b0;
    finish         = 1'b0;
    mem.mem_re     = 1'b0;
    mem.mem_we     = 1'b0;
    mem.mem_addr   = '0;
    mem.mem_wdata  = '0;
    unique case (state_q)
      IDLE: begin
        if (accept_ld)      state_d = LOAD;
        else if (accept_st) state_d = STORE;
      end
      LOAD: begin
        if (req_cnt < CNT_FULL) begin
          mem.mem_re   = 1'b1;
          mem.mem_addr = base_addr + ADDR_W'(req_cnt);
          req_fire     = mem.mem_rdy;
        end
        // Returns arrive in request order, so rsp_cnt alone names the slot.
        if (mem.mem_rvalid && (rsp_cnt < CNT_FULL)) begin
          capture = 1'b1;
          if (rsp_cnt == CNT_LAST) begin
            finish  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      STORE: begin
        mem.mem_we    = 1'b1;
        mem.mem_addr  = base_addr + ADDR_W'(req_cnt);
        mem.mem_wdata = st_buf[req_cnt[IDX_W-1:0]];
        req_fire      = mem.mem_rdy;
        if (mem.mem_rdy && (req_cnt == CNT_LAST)) begin
          finish  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Shadow with the beat being captured merged in, so ld_data updates on
  // the same edge that takes the final element.
  always_comb begin
    ld_next = '0;
    for (int i = 0; i < NELEM; i++) begin
      ld_next[i*ELEM_W +: ELEM_W] = (IDX_W'(i) == rsp_cnt[IDX_W-1:0]) ? mem.mem_rdata
                                                                      : shadow[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      req_cnt   <= '0;
      rsp_cnt   <= '0;
      base_addr <= '0;
      done      <= 1'b0;
      ld_data   <= '0;
    end else begin
      state_q <= state_d;
      done    <= finish;
      if (accept_ld || accept_st) begin
        base_addr <= addr;
        req_cnt   <= '0;
        rsp_cnt   <= '0;
      end else begin
        if (req_fire) req_cnt <= req_cnt + CNT_W'(1);
        if (capture)  rsp_cnt <= rsp_cnt + CNT_W'(1);
      end
      if (capture && (rsp_cnt == CNT_LAST)) ld_data <= ld_next;
    end
  end

  // NOTE: the element buffers are deliberately left without reset; they are
  // only read under counter control after being written in the same transfer.
  always_ff @(posedge clk) begin
    if (accept_st) begin
      for (int i = 0; i < NELEM; i++) st_buf[i] <= st_data[i*ELEM_W +: ELEM_W];
    end
    if (capture) shadow[rsp_cnt[IDX_W-1:0]] <= mem.mem_rdata;
  end

endmodule

// File: tb/tb_vec_ldst_unit.sv
// Bench for vec_ldst_unit: table of directed VLD/VST transfers against a
// latency/stall-configurable memory model, plus hand-written corner sequences.
module tb_vec_ldst_unit;
  localparam int ELEM_W = 16;
  localparam int NELEM  = 16;
  localparam int ADDR_W = 16;
  localparam logic [3:0] OP_VLD = 4'b0100;
  localparam logic [3:0] OP_VST = 4'b0101;

  typedef struct {
    bit          is_st;
    logic [15:0] a;
    logic [15:0] dbase;
    int          lat;
    bit          rnd;
    int          exp_done;   // cycle of done relative to start edge, 0 = not fixed
    logic [15:0] exp_last;   // address of element 15
  } vec_t;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
    int          cyc;
  } beat_t;

  typedef struct {
    logic [15:0] data;
    int          due;
  } pend_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [3:0]   opcode = 4'h0;
  logic [15:0]  addr = 16'h0;
  logic [255:0] st_data = '0;
  logic         busy, done;
  logic [255:0] ld_data;

  vec_ldst_unit_if #(.ADDR_W(ADDR_W), .ELEM_W(ELEM_W)) mem_bus ();

  vec_ldst_unit #(.ELEM_W(ELEM_W), .NELEM(NELEM), .ADDR_W(ADDR_W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .opcode  (opcode),
    .addr    (addr),
    .st_data (st_data),
    .busy    (busy),
    .done    (done),
    .ld_data (ld_data),
    .mem     (mem_bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int ncyc  = 0;
  always @(posedge clk) ncyc <= ncyc + 1;

  int  lat = 1;
  bit  rnd_rdy = 1'b0;
  int  done_cnt = 0, done_cyc = 0, done_base = 0, t0 = 0;
  int  stall_viol = 0, both_viol = 0, idle_viol = 0, busy_viol = 0;
  bit  stalled_prev = 1'b0;
  logic [33:0]  prev_req = '0;
  logic [255:0] ld_at_done = '0;
  logic [255:0] exp_ld = '0;
  beat_t wlog[$];
  beat_t rlog[$];
  pend_t pend[$];
  vec_t  vecs[6];

  task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [255:0] mk_vec(input logic [15:0] base);
    logic [255:0] v;
    for (int i = 0; i < NELEM; i++) v[i*16 +: 16] = base + 16'(i);
    return v;
  endfunction

  function automatic logic [255:0] load_vec(input logic [15:0] a);
    logic [255:0] v;
    for (int i = 0; i < NELEM; i++) v[i*16 +: 16] = (a + 16'(i)) ^ 16'h5555;
    return v;
  endfunction

  // Memory model: decides ready, returns reads in order after lat cycles,
  // logs accepted beats and tallies protocol violations.
  initial begin
    pend_t p;
    mem_bus.mem_rdy    = 1'b0;
    mem_bus.mem_rvalid = 1'b0;
    mem_bus.mem_rdata  = '0;
    forever begin
      @(negedge clk);
      if (stalled_prev && ({mem_bus.mem_re, mem_bus.mem_we, mem_bus.mem_addr, mem_bus.mem_wdata} !== prev_req))
        stall_viol++;
      if (mem_bus.mem_re && mem_bus.mem_we) both_viol++;
      if (!busy && (mem_bus.mem_re || mem_bus.mem_we || mem_bus.mem_addr != 0 || mem_bus.mem_wdata != 0))
        idle_viol++;
      if (done) begin
        done_cnt++;
        done_cyc   = ncyc;
        ld_at_done = ld_data;
        if (busy) busy_viol++;
      end
      if (pend.size() > 0 && pend[0].due <= ncyc) begin
        mem_bus.mem_rvalid = 1'b1;
        mem_bus.mem_rdata  = pend[0].data;
        void'(pend.pop_front());
      end else begin
        mem_bus.mem_rvalid = 1'b0;
        mem_bus.mem_rdata  = '0;
      end
      mem_bus.mem_rdy = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      if (mem_bus.mem_re && mem_bus.mem_rdy) begin
        p.data = mem_bus.mem_addr ^ 16'h5555;
        p.due  = ncyc + lat;
        pend.push_back(p);
        rlog.push_back('{mem_bus.mem_addr, 16'h0, ncyc});
      end
      if (mem_bus.mem_we && mem_bus.mem_rdy)
        wlog.push_back('{mem_bus.mem_addr, mem_bus.mem_wdata, ncyc});
      stalled_prev = (mem_bus.mem_re || mem_bus.mem_we) && !mem_bus.mem_rdy;
      prev_req = {mem_bus.mem_re, mem_bus.mem_we, mem_bus.mem_addr, mem_bus.mem_wdata};
    end
  end

  task automatic sync();
    @(posedge clk);
    #2;
  endtask

  // Called at posedge+2; start is held across the next (sampling) edge.
  task automatic launch(input logic [3:0] op, input logic [15:0] a, input logic [255:0] d);
    wlog.delete();
    rlog.delete();
    done_base = done_cnt + (done ? 1 : 0);
    start = 1'b1; opcode = op; addr = a; st_data = d;
    t0 = ncyc;
    sync();
    start = 1'b0; opcode = 4'h0; addr = 16'h0; st_data = '0;
  endtask

  task automatic verify(input vec_t v);
    int waited = 0;
    int aerr = 0, derr = 0;
    beat_t q[$];
    while (done_cnt == done_base && waited < 400) begin
      sync();
      waited++;
    end
    check("done_seen", 1'(done_cnt != done_base), 1'b1);
    if (v.exp_done != 0) check("done_cycle", done_cyc - t0, v.exp_done);
    if (v.is_st) q = wlog; else q = rlog;
    check("beats", q.size(), 16);
    if (q.size() == 16) check("last_addr", q[15].addr, v.exp_last);
    foreach (q[i]) if (q[i].addr !== v.a + 16'(i)) aerr++;
    check("addr_seq", aerr, 0);
    if (v.is_st) begin
      foreach (q[i]) if (q[i].data !== v.dbase + 16'(i)) derr++;
      check("wdata_seq", derr, 0);
      check("ld_hold", ld_data, exp_ld);
    end else begin
      exp_ld = load_vec(v.a);
      check("ld_at_done", ld_at_done, exp_ld);
    end
    if (!v.rnd && q.size() == 16) begin
      check("first_beat_cyc", q[0].cyc - t0, 1);
      check("last_beat_cyc", q[15].cyc - t0, 16);
    end
    repeat (3) sync();
    check("one_done", done_cnt - done_base, 1);
  endtask

  task automatic run_vec(input vec_t v);
    lat = v.lat;
    rnd_rdy = v.rnd;
    launch(v.is_st ? OP_VST : OP_VLD, v.a, v.is_st ? mk_vec(v.dbase) : '0);
    verify(v);
  endtask

  initial begin
    int d0;
    int guard;
    vecs[0] = '{1'b1, 16'h0100, 16'hA000, 1, 1'b0, 17, 16'h010F};
    vecs[1] = '{1'b0, 16'h0100, 16'h0000, 1, 1'b0, 18, 16'h010F};
    vecs[2] = '{1'b0, 16'hFFF8, 16'h0000, 1, 1'b0, 18, 16'h0007};
    vecs[3] = '{1'b0, 16'h1234, 16'h0000, 3, 1'b1, 0,  16'h1243};
    vecs[4] = '{1'b1, 16'hFFFC, 16'h5A00, 3, 1'b1, 0,  16'h000B};
    vecs[5] = '{1'b0, 16'h0020, 16'h0000, 4, 1'b0, 21, 16'h002F};

    repeat (2) sync();
    check("rst_outs", {busy, done, mem_bus.mem_re, mem_bus.mem_we, mem_bus.mem_addr, mem_bus.mem_wdata}, '0);
    check("rst_ld", ld_data, '0);
    rst_n = 1'b1;
    sync();

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Unrecognised opcode: no requests, no done, ld_data untouched.
    lat = 1; rnd_rdy = 1'b0;
    launch(4'b0000, 16'h0700, mk_vec(16'h1111));
    repeat (5) sync();
    check("badop_beats", wlog.size() + rlog.size(), 0);
    check("badop_done", done_cnt - done_base, 0);
    check("badop_busy", busy, 1'b0);
    check("badop_ld", ld_data, exp_ld);

    // Start while busy is ignored; start in the done cycle is accepted.
    d0 = done_cnt;
    launch(OP_VLD, 16'h0300, '0);
    sync();
    start = 1'b1; opcode = OP_VST; addr = 16'h0000; st_data = '1;
    sync();
    start = 1'b0; opcode = 4'h0; st_data = '0;
    guard = 0;
    while (ncyc < t0 + 18 && guard < 100) begin
      sync();
      guard++;
    end
    check("b2b_done_high", done, 1'b1);
    check("b2b_ld", ld_data, load_vec(16'h0300));
    check("busy_start_ignored", wlog.size(), 0);
    check("b2b_load_beats", rlog.size(), 16);
    exp_ld = load_vec(16'h0300);
    launch(OP_VST, 16'h0200, mk_vec(16'hC000));
    verify('{1'b1, 16'h0200, 16'hC000, 1, 1'b0, 17, 16'h020F});
    check("b2b_done_total", done_cnt - d0, 2);

    // Reset mid-load aborts; a following load completes normally.
    launch(OP_VLD, 16'h0400, '0);
    guard = 0;
    while (ncyc < t0 + 8 && guard < 100) begin
      sync();
      guard++;
    end
    d0 = done_cnt;
    rst_n = 1'b0;
    #1;
    check("rst_mid_outs", {busy, done, mem_bus.mem_re, mem_bus.mem_we, mem_bus.mem_addr, mem_bus.mem_wdata}, '0);
    check("rst_mid_ld", ld_data, '0);
    exp_ld = '0;
    pend.delete();
    stalled_prev = 1'b0;
    mem_bus.mem_rvalid = 1'b0;
    #1;
    rst_n = 1'b1;
    repeat (4) sync();
    check("rst_no_done", done_cnt - d0, 0);
    check("rst_idle", busy, 1'b0);
    run_vec('{1'b0, 16'h0500, 16'h0000, 1, 1'b0, 18, 16'h050F});

    check("protocol_viol", stall_viol + both_viol + idle_viol + busy_viol, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
